// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive/transmit path.
//
// Contents:
//   UART_DATA_W          - data bits per frame (matches the receive FIFO width)
//   CLKS_PER_BIT_DEFAULT - clocks per bit period for 100 MHz / 115200 baud
//   rx_state_t           - receive FSM state encoding
//   even_parity()        - even-parity bit of a data word
//
// Configuration macro: UART_RX_PARITY_EN adds the S_PARITY state (8E1 frames).
// Encodings are fixed so the state value seen on a debug port does not
// depend on whether the parity state is compiled in.

package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Even parity bit: 1 when the word holds an odd number of ones, so that
    // data plus parity bit carry an even count. Narrower words are passed in
    // zero-extended, which leaves the parity unchanged.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
//
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - synchronised output, two clk_i cycles behind d_i
//
// Both flops reset to 1 so an idle-high serial line looks idle straight out
// of reset instead of producing a spurious falling edge.

module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial receive front end of the UART-ALU path.
//
// Deserialises frames from rx and writes each good byte into the receive
// FIFO. Framing, overrun and (optionally) parity errors are reported as
// one-cycle pulses. All outputs are registered.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per bit period (even, >= 8)
//   WIDTH        - data bits per frame (must match the FIFO width, <= 32)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   rx          in   asynchronous serial input, idles high
//   full        in   FIFO full flag, looked at only when the stop bit is sampled
//   W_en        out  one-cycle FIFO write strobe
//   data_in     out  byte to the FIFO, valid with W_en, holds otherwise
//   frame_err   out  one-cycle pulse: stop bit sampled 0
//   overrun_err out  one-cycle pulse: good byte dropped because full=1
//   parity_err  out  one-cycle pulse: parity mismatch (0 without the macro)
//   busy        out  high in every state except idle
//   state_dbg   out  current FSM state (rx_state_t encoding)
//
// Handshake: the FIFO write port has no back-pressure beyond full; a byte is
// transferred in exactly the cycle W_en=1, and W_en is never raised while the
// full value sampled at the stop bit was 1.
//
// Configuration macro: UART_RX_PARITY_EN. Defined -> 8E1 frames with a
// PARITY state and live parity_err; undefined -> 8N1, parity_err tied 0.

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int WIDTH        = UART_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             full,
    output logic             W_en,
    output logic [WIDTH-1:0] data_in,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             parity_err,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic rx_s;

    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] data_q;
    logic             wen_q;
    logic             ferr_q;
    logic             oerr_q;
    logic             busy_q;
`ifdef UART_RX_PARITY_EN
    logic             perr_q;
    logic             perr_flag_q;
`endif

    sync_2ff u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            wen_q       <= 1'b0;
            ferr_q      <= 1'b0;
            oerr_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q      <= 1'b0;
            perr_flag_q <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle: cleared every cycle unless set below.
            wen_q  <= 1'b0;
            ferr_q <= 1'b0;
            oerr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!rx_s) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                // Re-check the line half a bit in; a high sample means the
                // falling edge was a glitch.
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // Sampling points sit a full bit after the start midpoint,
                // i.e. at the centre of each data bit. LSB arrives first.
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[WIDTH-1:1]};
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                // The mismatch is only remembered here; it is reported at the
                // stop bit so a framing error can take priority.
                S_PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q       <= '0;
                        perr_flag_q <= (rx_s != even_parity(32'(shift_q)));
                        state_q     <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif

                // Priority: framing, then parity, then overrun, then write.
                S_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            ferr_q  <= 1'b1;
                            state_q <= S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        end else if (perr_flag_q) begin
                            perr_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
`endif
                        end else if (full) begin
                            oerr_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            wen_q   <= 1'b1;
                            data_q  <= shift_q;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // A held-low line (break) must not be read as a stream of
                // zero bytes; wait for it to return high first.
                S_WAIT_HIGH: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign W_en        = wen_q;
    assign data_in     = data_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with CLKS_PER_BIT=16 and an
// 8-entry receive FIFO model (no reads; the bench empties it between tests).
// Build with +define+UART_RX_PARITY_EN to exercise the 8E1 variant.

module tb_uart_rx;
    import uart_pkg::*;

    localparam int C = 16;
    localparam int W = 8;
    localparam int FIFO_DEPTH = 8;
    // Cycles from the rx falling edge to W_en high.
    localparam int LAT = 2 + C / 2 + (W + 1) * C + 1
`ifdef UART_RX_PARITY_EN
        + C
`endif
        ;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_FERR = 2'd1;
    localparam logic [1:0] K_OERR = 2'd2;
    localparam logic [1:0] K_PERR = 2'd3;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [1:0] exp_kind;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx = 1'b1;
    logic         full;
    logic         W_en;
    logic [W-1:0] data_in;
    logic         frame_err;
    logic         overrun_err;
    logic         parity_err;
    logic         busy;
    logic [2:0]   state_dbg;

    int checks = 0;
    int failures = 0;
    int wr_total = 0;
    int fifo_base = 0;
    int pred_cnt = 0;
    logic [9:0] exp_q[$];

    vec_t vecs[8];

    assign full = ((wr_total - fifo_base) >= FIFO_DEPTH);

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(C), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .full        (full),
        .W_en        (W_en),
        .data_in     (data_in),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic put_bit(input logic b);
        rx = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] d);
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        put_bit(^d);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bits(d);
        put_bit(stop_b);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_p(input logic [7:0] d, input logic pbit);
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(d[i]);
        put_bit(pbit);
        put_bit(1'b1);
    endtask
`endif

    // Good frame: written while the model FIFO has room, overrun otherwise.
    task automatic expect_frame(input logic [7:0] d);
        if (pred_cnt < FIFO_DEPTH) begin
            exp_q.push_back({K_WR, d});
            pred_cnt++;
        end else begin
            exp_q.push_back({K_OERR, 8'h00});
        end
    endtask

    task automatic drain();
        fifo_base = wr_total;
        pred_cnt = 0;
    endtask

    task automatic check_empty(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic got_w;
        logic seen;
        int n;

        // Output monitor: every strobe is popped against the expected queue.
        fork
            begin : monitor
                int np;
                logic [9:0] got;
                logic [9:0] e;
                forever begin
                    @(negedge clk);
                    if (W_en || frame_err || overrun_err || parity_err) begin
                        np = int'(W_en) + int'(frame_err) + int'(overrun_err) + int'(parity_err);
                        check("pulse_onehot", np, 1);
                        if (W_en) begin
                            got = {K_WR, data_in};
                            wr_total++;
                        end else if (frame_err) begin
                            got = {K_FERR, 8'h00};
                        end else if (overrun_err) begin
                            got = {K_OERR, 8'h00};
                        end else begin
                            got = {K_PERR, 8'h00};
                        end
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_output: got %0h expected none", got);
                        end else begin
                            e = exp_q.pop_front();
                            check("output_event", got, e);
                        end
                    end
                end
            end
        join_none

        // Reset
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_W_en", W_en, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun_err", overrun_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_busy", busy, 0);
        check("rst_data_in", data_in, 0);
        check("rst_state", state_dbg, S_IDLE);
        @(negedge clk);
        reset = 1'b1;
        idle(5);

        // Single frame 0xA5 with latency measurement
        drain();
        expect_frame(8'hA5);
        cyc = 0;
        got_w = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!got_w && cyc < 400) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (W_en) got_w = 1'b1;
                end
            end
        join
        check("a5_latency", cyc, LAT);
        idle(10);
        check_empty("a5_drain");

        // Table-driven frames
        vecs[0] = '{8'h00, 1'b1, 0, K_WR};
        vecs[1] = '{8'hFF, 1'b1, 0, K_WR};
        vecs[2] = '{8'h55, 1'b1, 3, K_WR};
        vecs[3] = '{8'hAA, 1'b1, 0, K_WR};
        vecs[4] = '{8'h3C, 1'b0, 6, K_FERR};
        vecs[5] = '{8'h81, 1'b1, 0, K_WR};
        vecs[6] = '{8'h7E, 1'b1, 2, K_WR};
        vecs[7] = '{8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 12), K_WR};
        drain();
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_kind == K_WR) begin
                exp_q.push_back({K_WR, vecs[i].data});
                pred_cnt++;
            end else begin
                exp_q.push_back({vecs[i].exp_kind, 8'h00});
            end
            send_frame(vecs[i].data, vecs[i].stop);
            idle(vecs[i].gap);
        end
        idle(10);
        check_empty("table_drain");

        // Nine back-to-back frames into an 8-entry FIFO
        drain();
        for (int d = 2; d <= 10; d++) begin
            expect_frame(8'(d));
            send_frame(8'(d), 1'b1);
        end
        idle(10);
        check_empty("overrun_drain");
        check("fifo_full_after_overrun", full, 1);

        // Framing error followed by a held-low line
        drain();
        exp_q.push_back({K_FERR, 8'h00});
        send_bits(8'h3C);
        rx = 1'b0;
        repeat (C + 40) @(posedge clk);
        #1;
        check("break_state_wait_high", state_dbg, S_WAIT_HIGH);
        check("break_busy", busy, 1);
        idle(5);
        check("break_released_state", state_dbg, S_IDLE);
        check("break_released_busy", busy, 0);
        expect_frame(8'h11);
        send_frame(8'h11, 1'b1);
        idle(10);
        check_empty("break_drain");

        // Short low glitch on an idle line
        seen = 1'b0;
        rx = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen = seen | busy;
        end
        rx = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            seen = seen | busy;
            if (seen && !busy) break;
            n++;
        end
        check("glitch_busy_rose", seen, 1);
        check("glitch_busy_fell", busy, 0);
        idle(10);
        check_empty("glitch_drain");

`ifdef UART_RX_PARITY_EN
        // Parity: 0x3C has four ones, so the correct even parity bit is 0
        drain();
        exp_q.push_back({K_PERR, 8'h00});
        send_frame_p(8'h3C, 1'b1);
        idle(5);
        expect_frame(8'h3C);
        send_frame_p(8'h3C, 1'b0);
        idle(10);
        check_empty("parity_drain");
`endif

        // Reset in the middle of data bit 4
        drain();
        put_bit(1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        rx = 1'b0;
        repeat (C / 2) @(posedge clk);
        #1;
        check("midframe_busy_before_reset", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_W_en", W_en, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun_err", overrun_err, 0);
        check("midrst_parity_err", parity_err, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data_in", data_in, 0);
        check("midrst_state", state_dbg, S_IDLE);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        idle(2 * C);
        expect_frame(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(10);
        check_empty("post_reset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
